fetch_sequencer: RTL and testbench

//  Sequences the instruction transmitter: drives its sync request, captures each returned instruction

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/fetch_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch sequencer and its instruction queue.
//
// Contents:
//   ST_IDLE / ST_FETCH / ST_DRAIN / ST_DONE : sequencer state encoding
//   pc_width()                              : width of a word index into a
//                                             program of the given length
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A one-word program still needs a one-bit index, so never return zero.
    function automatic int pc_width(input int words);
        if (words <= 2) begin
            return 1;
        end
        return $clog2(words);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding instruction words (with their word index) between
// the transmitter and the decode handshake.
//
// Ports:
//   f_clk      in   clock
//   f_rst      in   asynchronous active-low reset
//   flush      in   empties the queue; wins over push and pop
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry (ignored when empty)
//   head_data  out  entry at the head; undefined content when empty
//   count      out  number of valid entries, 0..DEPTH
//   empty      out  count == 0
// DEPTH must be a power of two so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     f_clk,
    input  logic                     f_rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Qualified operations: a flush cancels any push or pop in the same cycle,
    // and overflow/underflow requests are dropped rather than corrupting state.
    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem[rd_ptr];

    // Storage array. It carries no reset: an entry is only ever read after a
    // push has written it, and the head is masked by the parent when empty.
    always_ff @(posedge f_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy. Simultaneous push and pop keep the count steady.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Drives the instruction transmitter's sync request, captures each returned
// word into a small queue and hands it to decode over valid/ready. Runs a
// single program pass or loops, withholds sync for back-pressure, and can be
// flushed at any time. It is the only agent driving the transmitter sync.
//
// Ports:
//   f_clk      in   clock shared with the transmitter
//   f_rst      in   asynchronous active-low reset (shared with transmitter)
//   f_i_start  in   pulse; starts a pass from IDLE or DONE
//   f_i_loop   in   keep fetching past PROG_LEN, wrapping the index
//   f_i_flush  in   pulse; abort and discard queued and in-flight words
//   f_o_syn    out  sync request to the transmitter
//   f_i_ack    in   transmitter acknowledge, one cycle after sync
//   f_i_instr  in   transmitter word, valid with f_i_ack
//   f_o_valid  out  decode word valid
//   f_i_ready  in   decode accepts the word
//   f_o_instr  out  head instruction (zero when nothing is queued)
//   f_o_pc     out  word index of f_o_instr (zero when nothing is queued)
//   f_o_busy   out  FETCH or DRAIN
//   f_o_done   out  DONE
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int  IWIDTH   = 32,
    parameter int  PROG_LEN = 36,
    parameter int  QDEPTH   = 4,
    localparam int PCW      = pc_width(PROG_LEN)
) (
    input  logic              f_clk,
    input  logic              f_rst,
    input  logic              f_i_start,
    input  logic              f_i_loop,
    input  logic              f_i_flush,
    output logic              f_o_syn,
    input  logic              f_i_ack,
    input  logic [IWIDTH-1:0] f_i_instr,
    output logic              f_o_valid,
    input  logic              f_i_ready,
    output logic [IWIDTH-1:0] f_o_instr,
    output logic [PCW-1:0]    f_o_pc,
    output logic              f_o_busy,
    output logic              f_o_done
);

    localparam int CNTW = $clog2(PROG_LEN + 1);
    localparam int QCW  = $clog2(QDEPTH) + 1;
    localparam int EW   = IWIDTH + PCW;

    localparam logic [CNTW-1:0] FULL_PASS = CNTW'(PROG_LEN);
    localparam logic [PCW-1:0]  LAST_PC   = PCW'(PROG_LEN - 1);
    localparam logic [QCW:0]    QLIMIT    = (QCW + 1)'(QDEPTH);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [CNTW-1:0] issue_cnt;
    logic            inflight;
    logic            discard;
    logic [PCW-1:0]  fetch_ptr;

    logic [QCW-1:0]  q_count;
    logic            q_empty;
    logic [EW-1:0]   q_head;

    logic            credit_ok;
    logic            issue_ok;
    logic            start_ok;
    logic            push;
    logic            pop;

    // Credit rule: a sync is only raised when the queue can absorb both the
    // word already on its way and the new one, so an ack never meets a full
    // queue. At most one word is ever in flight because inflight mirrors sync.
    assign credit_ok = ({1'b0, q_count} + {{QCW{1'b0}}, inflight}) < QLIMIT;
    assign issue_ok  = f_i_loop || (issue_cnt < FULL_PASS);
    assign f_o_syn   = (state == ST_FETCH) && credit_ok && issue_ok && !f_i_flush;

    // Acks arriving right after a flush belong to the aborted stream and are
    // dropped; a flush also wins over an ack arriving in its own cycle.
    assign push     = f_i_ack && !discard && !f_i_flush;
    assign pop      = f_o_valid && f_i_ready;
    assign start_ok = f_i_start && ((state == ST_IDLE) || (state == ST_DONE));

    // Decode side: head of the queue, forced to zero when nothing is queued.
    assign f_o_valid = !q_empty;
    assign f_o_instr = q_empty ? '0 : q_head[EW-1:PCW];
    assign f_o_pc    = q_empty ? '0 : q_head[PCW-1:0];
    assign f_o_busy  = (state == ST_FETCH) || (state == ST_DRAIN);
    assign f_o_done  = (state == ST_DONE);

    // Each queue entry carries the word together with its program index.
    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .f_clk     (f_clk),
        .f_rst     (f_rst),
        .flush     (f_i_flush),
        .push      (push),
        .push_data ({f_i_instr, fetch_ptr}),
        .pop       (pop),
        .head_data (q_head),
        .count     (q_count),
        .empty     (q_empty)
    );

    // Next-state logic. Flush overrides everything and returns to IDLE; start
    // is only honoured from IDLE or DONE. FETCH leaves once a non-looping pass
    // has issued every word; DRAIN waits for the last word to leave decode.
    always_comb begin
        state_nxt = state;
        if (f_i_flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (f_i_start) begin
                        state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!f_i_loop && (issue_cnt == FULL_PASS)) begin
                        state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!inflight && q_empty) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (f_i_start) begin
                        state_nxt = ST_FETCH;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In-flight tracking. discard only lives for the cycle after a flush.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            inflight <= f_o_syn;
            discard  <= f_i_flush ? inflight : 1'b0;
        end
    end

    // The fetch pointer follows the transmitter, so it steps on every ack,
    // including discarded ones; a flush deliberately does not rewind it.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            fetch_ptr <= '0;
        end else if (f_i_ack) begin
            fetch_ptr <= (fetch_ptr == LAST_PC) ? '0 : fetch_ptr + PCW'(1);
        end
    end

    // Issue counter: cleared by an accepted start, saturates at one full pass
    // so a looping run can be ended cleanly by dropping f_i_loop.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            issue_cnt <= '0;
        end else if (start_ok && !f_i_flush) begin
            issue_cnt <= '0;
        end else if (f_o_syn && (issue_cnt < FULL_PASS)) begin
            issue_cnt <= issue_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with a behavioural instruction
// transmitter (ack and word one cycle after each sync, shared reset).
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int IWIDTH   = 32;
    localparam int PROG_LEN = 36;
    localparam int QDEPTH   = 4;
    localparam int PCW      = 6;

    logic              f_clk = 1'b0;
    logic              f_rst = 1'b1;
    logic              f_i_start = 1'b0;
    logic              f_i_loop = 1'b0;
    logic              f_i_flush = 1'b0;
    logic              f_i_ready = 1'b0;
    logic              f_o_syn;
    logic              t_ack;
    logic [IWIDTH-1:0] t_instr;
    logic              f_o_valid;
    logic [IWIDTH-1:0] f_o_instr;
    logic [PCW-1:0]    f_o_pc;
    logic              f_o_busy;
    logic              f_o_done;

    int total = 0;
    int bad   = 0;
    int tx_ptr;

    int occ;
    int exp_pc;
    int delivered;
    int wraps;
    bit m_inflight;
    bit m_discard;

    always #5 f_clk = ~f_clk;

    fetch_sequencer #(
        .IWIDTH   (IWIDTH),
        .PROG_LEN (PROG_LEN),
        .QDEPTH   (QDEPTH)
    ) dut (
        .f_clk     (f_clk),
        .f_rst     (f_rst),
        .f_i_start (f_i_start),
        .f_i_loop  (f_i_loop),
        .f_i_flush (f_i_flush),
        .f_o_syn   (f_o_syn),
        .f_i_ack   (t_ack),
        .f_i_instr (t_instr),
        .f_o_valid (f_o_valid),
        .f_i_ready (f_i_ready),
        .f_o_instr (f_o_instr),
        .f_o_pc    (f_o_pc),
        .f_o_busy  (f_o_busy),
        .f_o_done  (f_o_done)
    );

    // Program contents held by the transmitter.
    function automatic logic [31:0] instr_word(input int idx);
        return 32'hC0DE_0000 + 32'(idx) * 32'h0001_0001;
    endfunction

    // Transmitter: a sync at one edge returns ack and the word at the next.
    always @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            t_ack   <= 1'b0;
            t_instr <= '0;
            tx_ptr  <= 0;
        end else begin
            t_ack <= f_o_syn;
            if (f_o_syn) begin
                t_instr <= instr_word(tx_ptr);
                tx_ptr  <= (tx_ptr == PROG_LEN - 1) ? 0 : tx_ptr + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        occ        = 0;
        m_inflight = 1'b0;
        m_discard  = 1'b0;
        exp_pc     = 0;
        delivered  = 0;
        wraps      = 0;
    endtask

    // Per-cycle bookkeeping, sampled at the falling edge before the next
    // rising edge: queue occupancy, credit, flush behaviour and word order.
    task automatic sampleCycle();
        bit do_pop;
        bit do_push;
        do_pop  = f_o_valid && f_i_ready && !f_i_flush;
        do_push = t_ack && !m_discard && !f_i_flush;
        checkOutput("valid_vs_queue", f_o_valid, occ != 0);
        if (occ + int'(m_inflight) >= QDEPTH) begin
            checkOutput("syn_credit", f_o_syn, 1'b0);
        end
        if (f_i_flush) begin
            checkOutput("flush_syn", f_o_syn, 1'b0);
        end
        if (do_pop) begin
            checkOutput("word_pc", f_o_pc, exp_pc);
            checkOutput("word_instr", f_o_instr, instr_word(exp_pc));
            if (exp_pc == PROG_LEN - 1) begin
                wraps++;
            end
            exp_pc = (exp_pc + 1) % PROG_LEN;
            delivered++;
        end
        occ        = f_i_flush ? 0 : occ + int'(do_push) - int'(do_pop);
        m_discard  = f_i_flush ? m_inflight : 1'b0;
        m_inflight = f_o_syn;
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic start, input logic loop, input logic flush, input logic ready);
        f_i_start = start;
        f_i_loop  = loop;
        f_i_flush = flush;
        f_i_ready = ready;
        @(negedge f_clk);
        sampleCycle();
        @(posedge f_clk);
        #1;
    endtask

    task automatic runUntilDone(input string tag, input int budget, input bit toggle);
        int n = 0;
        while (!f_o_done && n < budget) begin
            applyStimulus(1'b0, f_i_loop, 1'b0, toggle ? ~n[0] : 1'b1);
            n++;
        end
        checkOutput({tag, "_done"}, f_o_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        #2 f_rst = 1'b0;
        repeat (3) @(posedge f_clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_syn", f_o_syn, 1'b0);
        checkOutput("rst_valid", f_o_valid, 1'b0);
        checkOutput("rst_instr", f_o_instr, 32'h0);
        checkOutput("rst_pc", f_o_pc, 6'd0);
        checkOutput("rst_busy", f_o_busy, 1'b0);
        checkOutput("rst_done", f_o_done, 1'b0);
        f_rst = 1'b1;

        $display("[TB] test 1: single pass, ready high");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_busy", f_o_busy, 1'b1);
        runUntilDone("t1", 300, 1'b0);
        checkOutput("t1_words", delivered, 36);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("t1_syn_quiet", f_o_syn, 1'b0);
        end
        checkOutput("t1_done_hold", f_o_done, 1'b1);
        checkOutput("t1_busy_low", f_o_busy, 1'b0);
        checkOutput("t1_valid_low", f_o_valid, 1'b0);

        $display("[TB] test 2: back-pressure");
        delivered = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("t2_syn_held", f_o_syn, 1'b0);
        checkOutput("t2_queued", occ, 4);
        checkOutput("t2_valid", f_o_valid, 1'b1);
        checkOutput("t2_head_pc", f_o_pc, 6'd0);
        checkOutput("t2_head_instr", f_o_instr, instr_word(0));
        runUntilDone("t2", 300, 1'b0);
        checkOutput("t2_words", delivered, 36);

        $display("[TB] test 3: toggling ready");
        delivered = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runUntilDone("t3", 600, 1'b1);
        checkOutput("t3_words", delivered, 36);

        $display("[TB] test 4: flush with a word in flight");
        delivered = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("t4_pre_syn", f_o_syn, 1'b1);
        checkOutput("t4_pre_ack", t_ack, 1'b1);
        checkOutput("t4_pre_pc", f_o_pc, 6'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_valid", f_o_valid, 1'b0);
        checkOutput("t4_busy", f_o_busy, 1'b0);
        checkOutput("t4_done", f_o_done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("t4_still_empty", f_o_valid, 1'b0);
        checkOutput("t4_words_before", delivered, 1);
        delivered = 0;
        exp_pc    = 3;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        runUntilDone("t4", 300, 1'b0);
        checkOutput("t4_words", delivered, 36);

        $display("[TB] test 5: looping run");
        delivered = 0;
        wraps     = 0;
        exp_pc    = 3;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 400 && delivered < 80; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("t5_words", delivered, 80);
        checkOutput("t5_wraps", wraps, 2);
        checkOutput("t5_busy_loop", f_o_busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_drain_syn", f_o_syn, 1'b0);
        checkOutput("t5_drain_busy", f_o_busy, 1'b1);
        runUntilDone("t5", 100, 1'b0);
        checkOutput("t5_end_valid", f_o_valid, 1'b0);

        $display("[TB] test 6: reset during fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("t6_busy_before", f_o_busy, 1'b1);
        #2 f_rst = 1'b0;
        #1;
        checkOutput("t6_syn", f_o_syn, 1'b0);
        checkOutput("t6_valid", f_o_valid, 1'b0);
        checkOutput("t6_instr", f_o_instr, 32'h0);
        checkOutput("t6_pc", f_o_pc, 6'd0);
        checkOutput("t6_busy", f_o_busy, 1'b0);
        checkOutput("t6_done", f_o_done, 1'b0);
        resetModel();
        repeat (2) @(posedge f_clk);
        #1 f_rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_first_valid", f_o_valid, 1'b1);
        checkOutput("t6_first_pc", f_o_pc, 6'd0);
        checkOutput("t6_first_instr", f_o_instr, instr_word(0));
        runUntilDone("t6", 300, 1'b0);
        checkOutput("t6_words", delivered, 36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
